multicycle_ctrl: RTL

Multi-cycle main control sequencer for the RISC core. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives the `alu_op` code consumed by the ALU control decoder. It also drives the datapath mux selects and the register/memory/PC/IR write strobes, and handshakes with a single shared instruction/data memory port. It sits between the instruction register and the shared ALU/register-file/memory datapath, replacing single-cycle combinational control.

---
 rtl/multicycle_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control sequencer: steps each instruction through fetch/decode/execute/
// memory/writeback and decodes datapath selects and write strobes from the current state.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_WB_ALU   = 4'd7;
  localparam logic [3:0] S_WB_MEM   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_TRAP     = 4'd10;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [3:0]       r_state;
  logic [3:0]       w_next_state;
  logic [CNT_W-1:0] r_count;
  logic             r_illegal;
  logic             w_retire;

  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_reg_write;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Retired-instruction counter and sticky illegal flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (w_retire) begin
        r_count <= r_count + CNT_W'(1);
      end
      if (w_next_state == S_TRAP) begin
        r_illegal <= 1'b1;
      end
    end
  end

  assign w_retire = (w_next_state == S_FETCH) &&
                    ((r_state == S_MEM_WR) || (r_state == S_WB_ALU) ||
                     (r_state == S_WB_MEM) || (r_state == S_BRANCH));

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:    w_next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OP_R) begin
          w_next_state = S_EXEC_R;
        end else if (opcode == OP_I) begin
          w_next_state = S_EXEC_I;
        end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
          w_next_state = S_MEM_ADDR;
        end else if ((opcode == OP_BRANCH) && ((funct3 == 3'b000) || (funct3 == 3'b001))) begin
          w_next_state = S_BRANCH;
        end else begin
          w_next_state = S_TRAP;
        end
      end
      S_EXEC_R:   w_next_state = S_WB_ALU;
      S_EXEC_I:   w_next_state = S_WB_ALU;
      S_MEM_ADDR: begin
        if (opcode == OP_LOAD) begin
          w_next_state = S_MEM_RD;
        end else if (opcode == OP_STORE) begin
          w_next_state = S_MEM_WR;
        end else begin
          w_next_state = S_TRAP;
        end
      end
      S_MEM_RD:   w_next_state = mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:   w_next_state = mem_ready ? S_FETCH : S_MEM_WR;
      S_WB_ALU:   w_next_state = S_FETCH;
      S_WB_MEM:   w_next_state = S_FETCH;
      S_BRANCH:   w_next_state = S_FETCH;
      S_TRAP:     w_next_state = S_TRAP;
      default:    w_next_state = S_TRAP;
    endcase
  end

  // Output decode from current state
  always_comb begin
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_reg_write = 1'b0;
    i_or_d      = 1'b0;
    pc_src      = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    mem_to_reg  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        alu_src_b  = 2'b01;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b10;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        w_mem_read = 1'b1;
        i_or_d     = 1'b1;
      end
      S_MEM_WR: begin
        w_mem_write = 1'b1;
        i_or_d      = 1'b1;
      end
      S_WB_ALU: begin
        w_reg_write = 1'b1;
      end
      S_WB_MEM: begin
        w_reg_write = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 1'b1;
        if (funct3 == 3'b000) begin
          w_pc_write = zero;
        end else if (funct3 == 3'b001) begin
          w_pc_write = ~zero;
        end else begin
          w_pc_write = 1'b0;
        end
      end
      S_TRAP:  begin
        w_pc_write = 1'b0;
      end
      default: begin
        w_pc_write = 1'b0;
      end
    endcase
  end

  // Requests and strobes are suppressed while reset is held
  assign mem_read    = w_mem_read  & ~rst;
  assign mem_write   = w_mem_write & ~rst;
  assign ir_write    = w_ir_write  & ~rst;
  assign pc_write    = w_pc_write  & ~rst;
  assign reg_write   = w_reg_write & ~rst;
  assign illegal     = r_illegal;
  assign state       = r_state;
  assign instr_count = r_count;

endmodule
